// File: rtl/ddr2_v10_1_0002_sequencer_cpu_ocimem_ctrl_pkg.sv
// Shared constants for the sequencer CPU on-chip debug memory controller:
// address map, CTRL bit layout, jdo field positions and FSM states.
package ddr2_v10_1_0002_sequencer_cpu_ocimem_ctrl_pkg;

    localparam int RAM_DEPTH = 256;
    localparam int ADDR_W    = 9;
    localparam int RAM_AW    = 8;

    localparam logic [ADDR_W-1:0] CTRL_ADDR = 9'h100;

    localparam int CTRL_READY_BIT = 0;
    localparam int CTRL_ERROR_BIT = 1;
    localparam int CTRL_GO_BIT    = 2;

    localparam int JDO_RD_BIT      = 35;
    localparam int JDO_CLR_ERR_BIT = 24;
    localparam int JDO_GO_BIT      = 23;
    localparam int JDO_MONA_LSB    = 26;
    localparam int JDO_MOND_LSB    = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU_RD,
        ST_JTAG_RD
    } state_t;

    // Which source the CPU read data is taken from in the response cycle
    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_RAM,
        SEL_CTRL
    } rd_sel_t;

endpackage

// File: rtl/ddr2_v10_1_0002_sequencer_cpu_ocimem_ram.sv
// Single-port 32-bit debug RAM with byte enables and a registered read port.
module ddr2_v10_1_0002_sequencer_cpu_ocimem_ram
    import ddr2_v10_1_0002_sequencer_cpu_ocimem_ctrl_pkg::*;
#(
    parameter int DEPTH = RAM_DEPTH
) (
    input  logic              clk,
    input  logic [RAM_AW-1:0] addr,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       q
);

    logic [31:0] mem [DEPTH];

    // Read returns the pre-write contents when reading and writing the same word
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/ddr2_v10_1_0002_sequencer_cpu_ocimem_ctrl.sv
// Debug memory controller: arbitrates CPU slave accesses and JTAG monitor
// requests onto one debug RAM, and keeps the monitor handshake flags.
module ddr2_v10_1_0002_sequencer_cpu_ocimem_ctrl
    import ddr2_v10_1_0002_sequencer_cpu_ocimem_ctrl_pkg::*;
#(
    parameter int RAM_DEPTH = ddr2_v10_1_0002_sequencer_cpu_ocimem_ctrl_pkg::RAM_DEPTH
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    input  logic [8:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic        debugaccess,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic        monitor_go,
    output logic        jtag_overrun
);

    state_t  state, state_nxt;
    rd_sel_t rd_sel, rd_sel_nxt;

    logic [RAM_AW-1:0] MonAReg;
    logic              pend_rd, pend_wr;

    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_q;

    logic wait_c, ctrl_wr, jtag_wr_done, jtag_rd_done;

    logic cpu_rd, cpu_wr, is_ram, is_ctrl;
    logic any_action, pending, act_a_ok;

    assign cpu_rd     = chipselect & read;
    assign cpu_wr     = chipselect & write;
    assign is_ram     = ~address[8];
    assign is_ctrl    = (address == CTRL_ADDR);
    assign any_action = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign pending    = pend_rd | pend_wr;
    assign act_a_ok   = take_action_ocimem_a & ~pending;

    logic unused_jdo;
    assign unused_jdo = &{1'b0, jdo[37:36], jdo[25], jdo[2:0]};

    // CPU strobes always win the RAM port; JTAG only gets an idle, strobe-free cycle
    always_comb begin
        state_nxt    = state;
        rd_sel_nxt   = rd_sel;
        ram_addr     = address[RAM_AW-1:0];
        ram_we       = 1'b0;
        ram_be       = byteenable;
        ram_wdata    = writedata;
        wait_c       = 1'b0;
        readdata     = '0;
        ctrl_wr      = 1'b0;
        jtag_wr_done = 1'b0;
        jtag_rd_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_rd) begin
                    wait_c     = 1'b1;
                    state_nxt  = ST_CPU_RD;
                    rd_sel_nxt = is_ram ? SEL_RAM : (is_ctrl ? SEL_CTRL : SEL_ZERO);
                end else if (cpu_wr) begin
                    ram_we  = debugaccess & is_ram;
                    ctrl_wr = debugaccess & is_ctrl;
                end else if (pend_wr) begin
                    ram_addr     = MonAReg;
                    ram_we       = 1'b1;
                    ram_be       = 4'hF;
                    ram_wdata    = MonDReg;
                    jtag_wr_done = 1'b1;
                end else if (pend_rd) begin
                    ram_addr  = MonAReg;
                    state_nxt = ST_JTAG_RD;
                end
            end
            ST_CPU_RD: begin
                case (rd_sel)
                    SEL_RAM:  readdata = ram_q;
                    SEL_CTRL: readdata = {29'b0, monitor_go, monitor_error, monitor_ready};
                    default:  readdata = '0;
                endcase
                state_nxt = ST_IDLE;
            end
            ST_JTAG_RD: begin
                wait_c       = chipselect & (read | write);
                jtag_rd_done = 1'b1;
                state_nxt    = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign waitrequest = wait_c & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            rd_sel <= SEL_ZERO;
        end else begin
            state  <= state_nxt;
            rd_sel <= rd_sel_nxt;
        end
    end

    // A JTAG action arriving while a request is outstanding is dropped whole
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            MonAReg      <= '0;
            MonDReg      <= '0;
            pend_rd      <= 1'b0;
            pend_wr      <= 1'b0;
            jtag_overrun <= 1'b0;
        end else begin
            if (jtag_rd_done) begin
                MonDReg <= ram_q;
                pend_rd <= 1'b0;
            end
            if (jtag_wr_done) begin
                pend_wr <= 1'b0;
            end
            if (any_action) begin
                if (pending) begin
                    jtag_overrun <= 1'b1;
                end else if (take_action_ocimem_a) begin
                    MonAReg <= jdo[JDO_MONA_LSB +: RAM_AW];
                    if (jdo[JDO_RD_BIT]) begin
                        pend_rd <= 1'b1;
                    end
                end else if (take_action_ocimem_b) begin
                    MonDReg <= jdo[JDO_MOND_LSB +: 32];
                    pend_wr <= 1'b1;
                end else begin
                    MonAReg <= MonAReg + 8'd1;
                    pend_rd <= 1'b1;
                end
            end
        end
    end

    // Set terms are OR-ed after the clear terms so a simultaneous set wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            monitor_go    <= 1'b0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            monitor_go    <= (monitor_go & ~(ctrl_wr & writedata[CTRL_GO_BIT]))
                           | (act_a_ok & jdo[JDO_GO_BIT]);
            monitor_ready <= (monitor_ready & ~(act_a_ok & jdo[JDO_GO_BIT]))
                           | (ctrl_wr & writedata[CTRL_READY_BIT]);
            monitor_error <= (monitor_error & ~(act_a_ok & jdo[JDO_CLR_ERR_BIT]))
                           | (ctrl_wr & writedata[CTRL_ERROR_BIT]);
        end
    end

    ddr2_v10_1_0002_sequencer_cpu_ocimem_ram #(
        .DEPTH (RAM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we & reset_n),
        .be    (ram_be),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

endmodule

// File: tb/tb_ddr2_v10_1_0002_sequencer_cpu_ocimem_ctrl.sv
// Self-checking bench: directed and random CPU/JTAG traffic against a
// word-level model of the debug RAM, monitor registers and flags.
module tb_ddr2_v10_1_0002_sequencer_cpu_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [8:0]  address;
    logic        chipselect, read, write, debugaccess;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error, monitor_go, jtag_overrun;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_ram [256];
    bit          m_valid [256];
    logic [7:0]  validq [$];
    logic [7:0]  m_mon_a;
    logic [31:0] m_mon_d;
    logic        m_go, m_err, m_ready, m_overrun;

    always #5 clk = ~clk;

    ddr2_v10_1_0002_sequencer_cpu_ocimem_ctrl dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .address                 (address),
        .chipselect              (chipselect),
        .read                    (read),
        .write                   (write),
        .debugaccess             (debugaccess),
        .writedata               (writedata),
        .byteenable              (byteenable),
        .readdata                (readdata),
        .waitrequest             (waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .monitor_go              (monitor_go),
        .jtag_overrun            (jtag_overrun)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic checkFlags(input string tag);
        checkOutput(tag, {29'b0, monitor_go, monitor_error, monitor_ready},
                    {29'b0, m_go, m_err, m_ready});
    endtask

    task automatic markWritten(input logic [7:0] a);
        if (!m_valid[a]) begin
            m_valid[a] = 1'b1;
            validq.push_back(a);
        end
    endtask

    function automatic logic [7:0] pickValid();
        return validq[$urandom_range(0, validq.size() - 1)];
    endfunction

    function automatic logic [31:0] expRead(input logic [8:0] a);
        if (!a[8])            return m_ram[a[7:0]];
        else if (a == 9'h100) return {29'b0, m_go, m_err, m_ready};
        else                  return 32'h0;
    endfunction

    function automatic logic [37:0] mkJdoA(input logic [7:0] a, input logic rd, input logic go, input logic clr);
        logic [37:0] j;
        j = '0;
        j[33:26] = a;
        j[35] = rd;
        j[23] = go;
        j[24] = clr;
        return j;
    endfunction

    task automatic applyStimulus(input logic act_a, input logic act_b, input logic no_act, input logic [37:0] jdo_v);
        take_action_ocimem_a    = act_a;
        take_action_ocimem_b    = act_b;
        take_no_action_ocimem_a = no_act;
        jdo                     = jdo_v;
        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic jtagA(input logic [7:0] a, input logic rd, input logic go, input logic clr, input string tag);
        applyStimulus(1'b1, 1'b0, 1'b0, mkJdoA(a, rd, go, clr));
        tick();
        tick();
        m_mon_a = a;
        if (go) begin
            m_go = 1'b1;
            m_ready = 1'b0;
        end
        if (clr) m_err = 1'b0;
        if (rd) m_mon_d = m_ram[a];
        checkOutput({tag, "_mond"}, MonDReg, m_mon_d);
    endtask

    task automatic jtagB(input logic [31:0] d, input string tag);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        applyStimulus(1'b0, 1'b1, 1'b0, j);
        tick();
        tick();
        m_mon_d = d;
        m_ram[m_mon_a] = d;
        markWritten(m_mon_a);
        checkOutput({tag, "_mond"}, MonDReg, m_mon_d);
    endtask

    task automatic jtagNoAction(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b1, 38'h0);
        tick();
        tick();
        m_mon_a = m_mon_a + 8'd1;
        m_mon_d = m_ram[m_mon_a];
        checkOutput({tag, "_mond"}, MonDReg, m_mon_d);
    endtask

    task automatic cpuWrite(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be, input logic dbg, input string tag);
        chipselect = 1'b1; write = 1'b1; address = a;
        writedata = d; byteenable = be; debugaccess = dbg;
        #1;
        checkOutput({tag, "_wait"}, {31'b0, waitrequest}, 32'd0);
        tick();
        chipselect = 1'b0; write = 1'b0; debugaccess = 1'b0;
        if (dbg && !a[8]) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) m_ram[a[7:0]][8*i +: 8] = d[8*i +: 8];
        end else if (dbg && a == 9'h100) begin
            if (d[0]) m_ready = 1'b1;
            if (d[1]) m_err = 1'b1;
            if (d[2]) m_go = 1'b0;
        end
    endtask

    task automatic cpuRead(input logic [8:0] a, input string tag);
        logic [31:0] exp_d;
        int waits;
        exp_d = expRead(a);
        chipselect = 1'b1; read = 1'b1; address = a;
        waits = 0;
        #1;
        while (waitrequest === 1'b1 && waits < 10) begin
            waits++;
            tick();
        end
        checkOutput({tag, "_data"}, readdata, exp_d);
        checkOutput({tag, "_waits"}, 32'(waits), 32'd1);
        chipselect = 1'b0; read = 1'b0;
        tick();
    endtask

    task automatic resetModel();
        m_mon_a = '0; m_mon_d = '0;
        m_go = 1'b0; m_err = 1'b0; m_ready = 1'b0; m_overrun = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_wait"}, {31'b0, waitrequest}, 32'd0);
        checkOutput({tag, "_rdata"}, readdata, 32'd0);
        checkOutput({tag, "_mond"}, MonDReg, 32'd0);
        checkFlags({tag, "_flags"});
        checkOutput({tag, "_overrun"}, {31'b0, jtag_overrun}, 32'd0);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [8:0]  ua;
        logic [31:0] rd32;

        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
        address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0; debugaccess = 1'b0;
        writedata = '0; byteenable = '0;
        for (int i = 0; i < 256; i++) begin
            m_ram[i] = 'x;
            m_valid[i] = 1'b0;
        end
        resetModel();
        #1;
        checkResetOutputs("reset");
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // JTAG write then JTAG read back of word 0x10
        jtagA(8'h10, 1'b0, 1'b0, 1'b0, "jwr_addr");
        jtagB(32'hDEADBEEF, "jwr_data");
        applyStimulus(1'b0, 1'b1, 1'b0, 38'h0);
        $display("[TB] clobbering MonDReg before JTAG read-back");
        tick(); tick();
        m_mon_d = 32'h0; m_ram[8'h10] = 32'h0;
        jtagA(8'h10, 1'b0, 1'b0, 1'b0, "jwr_readdr");
        jtagB(32'hDEADBEEF, "jwr_rewrite");
        applyStimulus(1'b0, 1'b1, 1'b0, {3'b0, 32'h0, 3'b0});
        tick(); tick();
        m_mon_d = 32'h0; m_ram[8'h10] = 32'h0;
        jtagB(32'hDEADBEEF, "jwr_final");
        jtagA(8'h20, 1'b0, 1'b0, 1'b0, "jrd_move");
        jtagA(8'h10, 1'b1, 1'b0, 1'b0, "jrd_back");
        checkOutput("jtag_rd_deadbeef", MonDReg, 32'hDEADBEEF);

        // CPU byte-lane write and non-debug write discard
        cpuWrite(9'h010, 32'h0000AA00, 4'b0010, 1'b1, "cpu_bw");
        cpuRead(9'h010, "cpu_bw_rd");
        checkOutput("cpu_bw_value", m_ram[8'h10], 32'hDEADAAEF);
        cpuWrite(9'h010, 32'h12345678, 4'hF, 1'b0, "cpu_nodbg");
        cpuRead(9'h010, "cpu_nodbg_rd");

        // Auto-increment wraps 0xFF -> 0x00
        jtagA(8'h00, 1'b0, 1'b0, 1'b0, "wrap_a0");
        jtagB(32'hCAFEF00D, "wrap_d0");
        jtagA(8'hFF, 1'b0, 1'b0, 1'b0, "wrap_aff");
        jtagB(32'h0BADF00D, "wrap_dff");
        jtagA(8'hFF, 1'b1, 1'b0, 1'b0, "wrap_rdff");
        jtagNoAction("wrap_inc");
        jtagB(32'h11112222, "wrap_wr0");
        cpuRead(9'h000, "wrap_cpu_rd0");

        // Monitor handshake
        cpuWrite(9'h100, 32'h1, 4'hF, 1'b1, "hs_ready");
        checkFlags("hs_ready_flags");
        jtagA(8'h20, 1'b0, 1'b1, 1'b0, "hs_go");
        checkFlags("hs_go_flags");
        cpuWrite(9'h100, 32'h5, 4'hF, 1'b1, "hs_done");
        checkFlags("hs_done_flags");
        cpuRead(9'h100, "hs_ctrl_rd");
        cpuWrite(9'h100, 32'h2, 4'hF, 1'b1, "hs_err");
        checkFlags("hs_err_flags");
        jtagA(8'h20, 1'b0, 1'b0, 1'b1, "hs_clrerr");
        checkFlags("hs_clrerr_flags");

        // Set and clear of the same flag in one cycle resolve to set
        chipselect = 1'b1; write = 1'b1; debugaccess = 1'b1; address = 9'h100;
        writedata = 32'h5; byteenable = 4'hF;
        applyStimulus(1'b1, 1'b0, 1'b0, mkJdoA(8'h10, 1'b0, 1'b1, 1'b0));
        chipselect = 1'b0; write = 1'b0; debugaccess = 1'b0;
        tick();
        m_mon_a = 8'h10; m_go = 1'b1; m_ready = 1'b1;
        checkFlags("setclr_flags");

        // JTAG read pending across back-to-back CPU reads, plus a dropped action
        chipselect = 1'b1; read = 1'b1; address = 9'h010;
        applyStimulus(1'b1, 1'b0, 1'b0, mkJdoA(8'hFF, 1'b1, 1'b0, 1'b0));
        checkOutput("contend_rd0", readdata, m_ram[8'h10]);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mkJdoA(8'h00, 1'b1, 1'b0, 1'b0));
        m_overrun = 1'b1;
        checkOutput("contend_rd1", readdata, m_ram[8'h10]);
        checkOutput("contend_overrun", {31'b0, jtag_overrun}, {31'b0, m_overrun});
        checkOutput("contend_mond_hold", MonDReg, m_mon_d);
        tick();
        chipselect = 1'b0; read = 1'b0;
        tick();
        tick();
        m_mon_a = 8'hFF; m_mon_d = m_ram[8'hFF];
        checkOutput("contend_served", MonDReg, m_mon_d);
        jtagB(32'h600DCAFE, "contend_mona");
        cpuRead(9'h0FF, "contend_mona_rd");

        // Randomised mix of CPU and JTAG traffic
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: begin
                    ra = 8'($urandom_range(0, 255));
                    jtagA(ra, 1'b0, 1'b0, 1'b0, "rnd_ja");
                    jtagB($urandom, "rnd_jb");
                end
                1: begin
                    ra = pickValid();
                    cpuWrite({1'b0, ra}, $urandom, 4'($urandom_range(0, 15)), 1'b1, "rnd_cw");
                end
                2: cpuRead({1'b0, pickValid()}, "rnd_cr");
                3: jtagA(pickValid(), 1'b1, 1'b0, 1'b0, "rnd_jr");
                default: begin
                    ua = 9'h101 + 9'($urandom_range(0, 254));
                    cpuRead(ua, "rnd_unmapped");
                end
            endcase
        end
        checkOutput("rnd_overrun", {31'b0, jtag_overrun}, {31'b0, m_overrun});

        // Reset while the CPU read is in its response cycle
        rd32 = m_ram[8'h10];
        chipselect = 1'b1; read = 1'b1; address = 9'h010;
        #1;
        tick();
        reset_n = 1'b0;
        resetModel();
        #1;
        checkResetOutputs("midrd_reset");
        chipselect = 1'b0; read = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        cpuRead(9'h010, "post_reset_rd");
        checkOutput("post_reset_ram", m_ram[8'h10], rd32);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr2_v10_1_0002_sequencer_cpu_ocimem_ctrl.md
DDR2_V10_1_0002_SEQUENCER_CPU_OCIMEM_CTRL -- requirements
Module: ddr2_v10_1_0002_sequencer_cpu_ocimem_ctrl

Interface
REQ-001 Parameter: RAM_DEPTH, default 256, debug RAM words of 32 bits.
REQ-002 The block SHALL have exactly one clock, clk, and an asynchronous, active-low reset, reset_n.
REQ-003 Ports SHALL be:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- jdo  in  38  JTAG data from the debug-module sysclk stage
- take_action_ocimem_a  in  1  load address / monitor control
- take_action_ocimem_b  in  1  load data and write
- take_no_action_ocimem_a  in  1  auto-increment and read
- address  in  9  CPU word address
- chipselect, read, write, debugaccess  in  1 each  CPU slave strobes
- writedata  in  32  CPU write data
- byteenable  in  4  CPU byte lanes
- readdata  out  32  CPU read data
- waitrequest  out  1  CPU stall
- MonDReg  out  32  monitor data register, to JTAG tck stage
- monitor_ready, monitor_error, monitor_go  out  1 each  monitor handshake flags
- jtag_overrun  out  1  sticky, JTAG request dropped

Function
REQ-004 Address map: address[8]=0 selects RAM word address[7:0]; address 0x100 is CTRL; other addresses read 0 and ignore writes.
REQ-005 take_action_ocimem_a SHALL:
- load MonAReg <= jdo[33:26];
- if jdo[35]=1, set a JTAG read pending;
- if jdo[23]=1, set monitor_go and clear monitor_ready;
- if jdo[24]=1, clear monitor_error.
REQ-006 take_action_ocimem_b SHALL load MonDReg <= jdo[34:3] and set a JTAG write pending to MonAReg.
REQ-007 take_no_action_ocimem_a SHALL increment MonAReg modulo 256, wrapping 0xFF->0x00, and set a JTAG read pending at the new address.
REQ-008 At most one JTAG request SHALL be pending; a new action while one is pending SHALL be dropped (no register change) and set jtag_overrun.
REQ-009 FSM states: IDLE, CPU_RD, JTAG_RD.
REQ-010 IDLE with chipselect&read SHALL:
- issue the RAM/CTRL read;
- assert waitrequest=1;
- go to CPU_RD.
REQ-011 CPU_RD SHALL drive waitrequest=0 and readdata=RAM q (or CTRL = {29'b0, monitor_go, monitor_error, monitor_ready}), then return to IDLE; CPU read latency is 2 cycles.
REQ-012 IDLE with chipselect&write SHALL complete in one cycle with waitrequest=0.
REQ-013 CPU RAM writes SHALL take effect only with debugaccess=1, honouring byteenable; otherwise the write is accepted and discarded.
REQ-014 CPU CTRL write with debugaccess=1 SHALL:
- set monitor_ready if writedata[0]=1;
- set monitor_error if writedata[1]=1;
- clear monitor_go if writedata[2]=1.
REQ-015 The CPU SHALL have priority; a JTAG pending request SHALL be served only in IDLE with no CPU strobe.
REQ-016 A JTAG write SHALL write MonDReg to ram[MonAReg], all lanes, in one cycle, then clear pending.
REQ-017 A JTAG read SHALL issue a RAM read and go to JTAG_RD; in JTAG_RD, MonDReg <= RAM q, pending clears, and the FSM returns to IDLE.
REQ-018 A JTAG action and a CPU strobe in the same cycle SHALL both be accepted: the action is registered and the CPU access proceeds.
REQ-019 Simultaneous set and clear of the same flag SHALL resolve to set.
REQ-020 waitrequest SHALL be 0 when chipselect=0.

Reset
REQ-021 On reset_n low, asynchronously, the block SHALL force:
- FSM to IDLE;
- MonAReg, MonDReg, readdata to 0;
- all flags and pending bits to 0;
- waitrequest to 0.
RAM contents SHALL NOT be reset.
REQ-022 Reset mid-access SHALL abandon the access; no RAM write SHALL occur in the reset cycle.

Structure
REQ-023 A shared package SHALL hold RAM_DEPTH, the address width, the CTRL offset 0x100, the CTRL bit indices, the jdo field positions and the FSM state enumeration.
REQ-024 One sub-module SHALL be used: ddr2_v10_1_0002_sequencer_cpu_ocimem_ram, a single-port 256x32 RAM with byte enables and registered one-cycle read.

Verification
REQ-025 JTAG write then read: action_a with jdo[33:26]=0x10, then action_b with jdo[34:3]=0xDEADBEEF, then action_a with addr 0x10 and jdo[35]=1 -> MonDReg=0xDEADBEEF within 2 cycles.
REQ-026 Auto-increment wrap: MonAReg=0xFF, take_no_action_ocimem_a -> read of ram[0x00]; MonAReg=0x00.
REQ-027 CPU byte write: debugaccess=1, address 0x010, byteenable=4'b0010, writedata=0x0000AA00 over 0xDEADBEEF -> CPU read returns 0xDEADAAEF with waitrequest high for exactly 1 cycle.
REQ-028 Contention: JTAG read pending while the CPU issues back-to-back reads -> JTAG is served in the first idle cycle; a second JTAG action while pending -> jtag_overrun=1 and MonAReg unchanged.
REQ-029 Handshake: action_a with jdo[23]=1 -> monitor_go=1, monitor_ready=0; CPU write 0x5 to 0x100 -> monitor_ready=1, monitor_go=0; CTRL reads 0x1.
REQ-030 Reset asserted in CPU_RD -> waitrequest=0, FSM IDLE, all outputs 0; RAM data intact on a subsequent read.
